// File: rtl/ber_readout.sv
// ber_readout
//   Readout stage behind the BER counter. A snapshot command captures the
//   64-bit error and bit counts together and streams them to the host as a
//   five-word record: header, errors hi/lo, bits hi/lo. A clear command
//   holds the BER stage in reset for CLEAR_CYCLES cycles.
//
// Ports
//   clock          rising-edge clock
//   i_reset        async assert, active-low reset
//   i_errors       error count from the BER stage
//   i_bits         compared-bit count from the BER stage
//   i_cmd_valid    command strobe
//   i_cmd          2'b01 snapshot, 2'b10 clear, other codes illegal
//   o_cmd_ready    high only while idle
//   o_ber_reset    active-high synchronous reset to the BER stage
//   o_data         record word (registered)
//   o_data_valid   o_data holds a word of the record
//   i_data_ready   downstream accepts the current word
//   o_cmd_err      one-cycle pulse after an accepted illegal command
//   o_seq          completed snapshots, modulo 256
module ber_readout #(
  parameter int unsigned NB_COUNT     = 64,
  parameter int unsigned NB_WORD      = 32,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter logic [7:0]  HEADER_TAG   = 8'hA5
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [NB_COUNT-1:0] i_errors,
  input  logic [NB_COUNT-1:0] i_bits,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  output logic                o_ber_reset,
  output logic [NB_WORD-1:0]  o_data,
  output logic                o_data_valid,
  input  logic                i_data_ready,
  output logic                o_cmd_err,
  output logic [7:0]          o_seq
);

  localparam logic [1:0] CMD_SNAP  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [2:0] LAST_IDX  = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NB_COUNT-1:0] err_q, err_d;
  logic [NB_COUNT-1:0] bits_q, bits_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          clr_q, clr_d;
  logic [NB_WORD-1:0]  data_q, data_d;
  logic                valid_q, valid_d;
  logic                ber_q, ber_d;
  logic                cmd_err_q, cmd_err_d;
  logic [7:0]          seq_q, seq_d;

  logic cmd_fire;
  assign cmd_fire = i_cmd_valid && (state_q == IDLE);

  // Payload word for a given record index; the header is built at accept
  // time, so only indices 1..4 are looked up here.
  function automatic logic [NB_WORD-1:0] payload_word(
    input logic [2:0]          idx,
    input logic [NB_COUNT-1:0] errs,
    input logic [NB_COUNT-1:0] bits
  );
    logic [NB_WORD-1:0] w;
    w = '0;
    case (idx)
      3'd1:    w = errs[NB_COUNT-1 -: NB_WORD];
      3'd2:    w = errs[NB_WORD-1:0];
      3'd3:    w = bits[NB_COUNT-1 -: NB_WORD];
      3'd4:    w = bits[NB_WORD-1:0];
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    state_d   = state_q;
    err_d     = err_q;
    bits_d    = bits_q;
    idx_d     = idx_q;
    clr_d     = clr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ber_d     = ber_q;
    cmd_err_d = 1'b0;
    seq_d     = seq_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          case (i_cmd)
            CMD_SNAP: begin
              // Both counts are captured on the same edge so the record is
              // a consistent pair even though the BER stage keeps counting.
              err_d   = i_errors;
              bits_d  = i_bits;
              idx_d   = 3'd0;
              data_d  = {HEADER_TAG, seq_q, {(NB_WORD-16){1'b0}}};
              valid_d = 1'b1;
              state_d = SEND;
            end
            CMD_CLEAR: begin
              clr_d   = 8'(CLEAR_CYCLES);
              ber_d   = 1'b1;
              state_d = CLEAR;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end

      SEND: begin
        if (valid_q && i_data_ready) begin
          if (idx_q == LAST_IDX) begin
            seq_d   = seq_q + 8'd1;
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = payload_word(idx_q + 3'd1, err_q, bits_q);
          end
        end
      end

      CLEAR: begin
        // The counter value seen here is the number of reset cycles still
        // being driven, including the current one.
        if (clr_q <= 8'd1) begin
          clr_d   = 8'd0;
          ber_d   = 1'b0;
          state_d = IDLE;
        end else begin
          clr_d = clr_q - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: the snapshot registers are small enough to reset like any
      // other flop; a stale capture must never leak into a later record.
      state_q   <= IDLE;
      err_q     <= '0;
      bits_q    <= '0;
      idx_q     <= '0;
      clr_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ber_q     <= 1'b0;
      cmd_err_q <= 1'b0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      bits_q    <= bits_d;
      idx_q     <= idx_d;
      clr_q     <= clr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ber_q     <= ber_d;
      cmd_err_q <= cmd_err_d;
      seq_q     <= seq_d;
    end
  end

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_ber_reset  = ber_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_cmd_err    = cmd_err_q;
  assign o_seq        = seq_q;

endmodule

// File: doc/ber_readout.md
Name: ber_readout

Overview:
- Downstream consumer of the BER counter stage: takes its 64-bit error and bit counts and returns them to the host.
- On a snapshot command, captures both counts atomically and streams a 5-word, 32-bit framed record over a valid/ready handshake.
- On a clear command, drives the BER stage's synchronous reset for a fixed number of cycles, which also restarts its latency search.

Parameters:
- NB_COUNT, 64, width of i_errors / i_bits; must equal 2*NB_WORD.
- NB_WORD, 32, width of o_data.
- CLEAR_CYCLES, 4, cycles o_ber_reset is held high per clear command; legal range 1..255.
- HEADER_TAG, 8'hA5, constant placed in o_data[31:24] of the header word.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- i_reset  in  1  reset, asynchronous assert, active-low (0 = reset); released synchronously to clock.
- i_errors  in  NB_COUNT  error count from the BER stage.
- i_bits  in  NB_COUNT  compared-bit count from the BER stage.
- i_cmd_valid  in  1  command strobe.
- i_cmd  in  2  command code: 2'b01 = snapshot, 2'b10 = clear; 2'b00 and 2'b11 are illegal.
- o_cmd_ready  out  1  high only in IDLE; a command is accepted when i_cmd_valid & o_cmd_ready.
- o_ber_reset  out  1  active-high synchronous reset to the BER stage.
- o_data  out  NB_WORD  record word.
- o_data_valid  out  1  o_data is valid.
- i_data_ready  in  1  downstream accepts the word; transfer = o_data_valid & i_data_ready.
- o_cmd_err  out  1  one-cycle pulse on an accepted illegal command.
- o_seq  out  8  number of snapshots completed, modulo 256.

Behaviour:
- Reset (i_reset = 0): every register is cleared immediately. State goes to IDLE.
  - Reset values: o_cmd_ready = 1, o_ber_reset = 0, o_data = 0, o_data_valid = 0, o_cmd_err = 0, o_seq = 0.
  - Snapshot registers and word index = 0; clear counter = 0.
- FSM states: IDLE, SEND, CLEAR.
- IDLE:
  - Snapshot accepted: i_errors and i_bits are latched in that same edge, word index = 0, next state SEND.
  - o_data_valid rises on the cycle after acceptance.
  - Clear accepted: clear counter = CLEAR_CYCLES, next state CLEAR.
  - Illegal code accepted: o_cmd_err pulses for exactly one cycle on the next cycle; state stays IDLE.
- SEND: o_data_valid = 1 throughout. Words in order by index:
  - 0: {HEADER_TAG, o_seq, 16'd0}
  - 1: errors[63:32]
  - 2: errors[31:0]
  - 3: bits[63:32]
  - 4: bits[31:0]
- SEND handshake rules:
  - Each transfer advances the index.
  - While i_data_ready = 0, o_data and o_data_valid hold stable.
  - o_data is driven from a register, so the word updates the cycle after a transfer. Back-to-back transfers at one word per cycle are supported.
  - Transfer of word 4: o_seq increments (8'hFF wraps to 8'h00), o_data_valid falls the next cycle, state returns to IDLE.
- Snapshot consistency: the latched values do not change during SEND, even though i_errors / i_bits keep moving.
- CLEAR:
  - o_ber_reset = 1 for exactly CLEAR_CYCLES consecutive cycles, starting the cycle after acceptance.
  - The counter decrements each cycle; when it reaches 0, o_ber_reset drops and the state returns to IDLE.
  - o_seq is not affected.
- Commands outside IDLE: o_cmd_ready = 0, so they are not accepted. They are silently dropped (no error pulse) unless the requester holds i_cmd_valid.
- o_cmd_ready returns high on the first cycle back in IDLE; a new command may be accepted that same cycle.
- Reset mid-SEND: the record is abandoned, o_data_valid = 0 immediately, o_seq = 0.
- Reset mid-CLEAR: o_ber_reset = 0 immediately.
- Not required: no backpressure timeout, no partial-record recovery.

Test Plan:
- Snapshot with i_errors = 64'h0000_0001_0000_0002, i_bits = 64'h0000_0000_FFFF_FFFF, i_data_ready = 1 -> five consecutive words A500_0000, 0000_0001, 0000_0002, 0000_0000, FFFF_FFFF; o_seq becomes 1.
- Snapshot, then i_errors changed every cycle and i_data_ready toggled 1,0,0,1,... -> words match the values at acceptance; o_data stable while ready = 0; no word duplicated or skipped.
- Clear with CLEAR_CYCLES = 4 -> o_ber_reset high for exactly 4 cycles starting 1 cycle after acceptance; o_cmd_ready low for those cycles, high the cycle after.
- i_cmd = 2'b11 in IDLE -> single-cycle o_cmd_err, no state change. Snapshot command issued during SEND -> ignored, current record unaffected.
- 256 snapshots -> header seq byte runs 00..FF, then 00; the 257th header reads A500_0000.
- i_reset driven low at the transfer of word 2 -> o_data_valid = 0 asynchronously, o_seq = 0. The next snapshot starts with header A500_0000.
